// File: rtl/mips_enc_pkg.sv
// Shared constants for the MIPS instruction encoder:
// class bit positions, opcode prefixes and word width.
package mips_enc_pkg;

    localparam int WORD_W = 32;

    localparam int CLS_R  = 0;
    localparam int CLS_B1 = 1;
    localparam int CLS_J  = 2;
    localparam int CLS_B2 = 3;
    localparam int CLS_I  = 4;
    localparam int CLS_F  = 5;
    localparam int CLS_M  = 6;

    localparam logic [5:0] OP_R  = 6'b000000;
    localparam logic [5:0] OP_F  = 6'b010001;
    localparam logic [5:0] OP_B1 = 6'b000001;
    localparam logic [4:0] OP_J  = 5'b00001;
    localparam logic [3:0] OP_B2 = 4'b0001;
    localparam logic [2:0] OP_I  = 3'b001;
    localparam logic [1:0] OP_M  = 2'b10;

endpackage

// File: rtl/mips_instr_encoder_fifo.sv
// Output buffer for encoded words: registered occupancy,
// pointers wrapping modulo DEPTH, no write-through when full.
module enc_fifo
    import mips_enc_pkg::*;
#(
    parameter int W     = WORD_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign valid_o = (cnt_q != '0);
    assign data_o  = mem_q[rd_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && valid_o;
    assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage needs no reset: occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Encodes one-hot class requests into MIPS words, buffers
// them in enc_fifo and keeps issue/error statistics.
module mips_instr_encoder
    import mips_enc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        cls,
    input  logic [3:0]        sub,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] instr,
    output logic              err_pulse,
    output logic [15:0]       issued_cnt,
    output logic [15:0]       err_cnt
);

    logic              full, acc, legal;
    logic [WORD_W-1:0] word_d;
    logic              errp_q;
    logic [15:0]       iss_q, err_q;

    assign legal    = (cls != '0) && ((cls & (cls - 7'd1)) == '0);
    assign in_ready = rst_n && !full;
    assign acc      = in_valid && in_ready;

    // Only a legal one-hot class reaches the decoder.
    always_comb begin
        word_d = '0;
        if (legal) begin
            unique case (1'b1)
                cls[CLS_R]:  word_d = {OP_R, rs, rt, rd, shamt, funct};
                cls[CLS_F]:  word_d = {OP_F, rs, rt, rd, shamt, funct};
                cls[CLS_B1]: word_d = {OP_B1, rs, rt, imm};
                cls[CLS_J]:  word_d = {OP_J, sub[0], target};
                cls[CLS_B2]: word_d = {OP_B2, sub[1:0], rs, rt, imm};
                cls[CLS_I]:  word_d = {OP_I, sub[2:0], rs, rt, imm};
                cls[CLS_M]:  word_d = {OP_M, sub, rs, rt, imm};
                default:     word_d = '0;
            endcase
        end
    end

    enc_fifo #(
        .W     (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (acc && legal),
        .data_i  (word_d),
        .pop_i   (out_ready),
        .full_o  (full),
        .valid_o (out_valid),
        .data_o  (instr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            errp_q <= 1'b0;
            iss_q  <= '0;
            err_q  <= '0;
        end else begin
            errp_q <= acc && !legal;
            if (acc && legal && iss_q != 16'hFFFF)
                iss_q <= iss_q + 16'd1;
            if (acc && !legal && err_q != 16'hFFFF)
                err_q <= err_q + 16'd1;
        end
    end

    assign err_pulse  = errp_q;
    assign issued_cnt = iss_q;
    assign err_cnt    = err_q;

endmodule
